// File: rtl/aes_encrypt_core_if.sv
// Plaintext-in / ciphertext-out handshake bundle for the AES-128 core, plus the expanded key bus.
// The master side is the upstream key-expansion/source stage together with the ciphertext consumer.
interface aes_encrypt_core_if;
  logic [1407:0] round_keys;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  data_in;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  data_out;

  modport master (
    output round_keys, in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  round_keys, in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption, one full round per clock.
// state | meaning
// IDLE  | ready for plaintext; initial AddRoundKey is applied on accept
// ROUND | rounds 1..10 in progress, rc selects the round key
// DONE  | ciphertext on data_out, waiting for out_ready
module aes_encrypt_core (
  input  logic              clk,
  input  logic              rst,
  aes_encrypt_core_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rc_q, rc_d;
  logic [127:0] state_q, state_d;
  logic [127:0] dout_q, dout_d;

  logic [127:0] sb, sr, mc, rk0, rkr, key_blk, rnd_out;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // round_keys is not registered: rc picks the 128-bit round-key block straight off the bus
  assign key_blk = bus.round_keys[{rc_q, 7'd0} +: 128];

  for (genvar n = 0; n < 16; n++) begin : g_byte
    localparam int C = n / 4;
    localparam int R = n % 4;
    assign sb[8*n +: 8]  = sbox(state_q[8*n +: 8]);
    assign sr[8*n +: 8]  = sb[8*(4*((C + R) % 4) + R) +: 8];
    assign rk0[8*n +: 8] = bus.round_keys[32*C + 31 - 8*R -: 8];
    assign rkr[8*n +: 8] = key_blk[32*C + 31 - 8*R -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[32*c      +: 8];
    assign a1 = sr[32*c + 8  +: 8];
    assign a2 = sr[32*c + 16 +: 8];
    assign a3 = sr[32*c + 24 +: 8];
    assign mc[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  assign rnd_out = ((rc_q == 4'd10) ? sr : mc) ^ rkr;

  always_comb begin
    fsm_d   = fsm_q;
    rc_d    = rc_q;
    state_d = state_q;
    dout_d  = dout_q;
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.data_in ^ rk0;
          rc_d    = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = rnd_out;
        rc_d    = rc_q + 4'd1;
        if (rc_q == 4'd10) begin
          dout_d = rnd_out;
          rc_d   = 4'd0;
          fsm_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      rc_q    <= 4'd0;
      state_q <= 128'h0;
      dout_q  <= 128'h0;
    end else begin
      fsm_q   <= fsm_d;
      rc_q    <= rc_d;
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.data_out  = dout_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Bench for aes_encrypt_core: independent AES-128 model (computed S-box, key expansion)
// feeding a scoreboard queue, plus FIPS-197 known-answer vectors.
module tb_aes_encrypt_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [127:0] sb_q[$];
  logic [7:0]   sbox_t [256];

  localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] B_KEY  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] B_PT   = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] B_R1   = 128'h49506a0243ea5b6b2b359f68f27f9ca4;
  localparam logic [127:0] B_CT   = 128'h320b6a19978511dcfb09dc021d842539;

  aes_encrypt_core_if bus();
  aes_encrypt_core dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // rc must stay within 1..10 whenever the core is mid-encryption
  initial forever begin
    @(negedge clk);
    if (!rst && bus.in_ready === 1'b0 && bus.out_valid === 1'b0) begin
      checks++;
      if (dut.rc_q < 4'd1 || dut.rc_q > 4'd10) begin
        errors++;
        $display("FAIL rc_range: rc=%0d required 1..10", dut.rc_q);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? (8'(aa << 1) ^ 8'h1b) : 8'(aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(b));
      sbox_t[8'(b)] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] gb(input logic [127:0] s, input int n);
    return 8'(s >> (8*n));
  endfunction

  function automatic logic [127:0] pb(input logic [127:0] s, input int n, input logic [7:0] v);
    return (s & ~(128'hff << (8*n))) | (128'(v) << (8*n));
  endfunction

  function automatic logic [7:0] rkb(input logic [1407:0] rk, input int r, input int n);
    return 8'(rk >> ((4*r + n/4)*32 + 24 - 8*(n%4)));
  endfunction

  function automatic logic [1407:0] key_expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] rk;
    for (int i = 0; i < 4; i++)
      w[6'(i)] = {gb(key, 4*i), gb(key, 4*i+1), gb(key, 4*i+2), gb(key, 4*i+3)};
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[6'(i-1)];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = gmul(rcon, 8'h02);
      end
      w[6'(i)] = w[6'(i-4)] ^ t;
    end
    rk = '0;
    for (int i = 0; i < 44; i++) rk = rk | (1408'(w[6'(i)]) << (32*i));
    return rk;
  endfunction

  function automatic logic [127:0] model_enc(input logic [1407:0] rk, input logic [127:0] pt);
    logic [127:0] s, t, m;
    logic [7:0]   a0, a1, a2, a3;
    s = '0;
    for (int n = 0; n < 16; n++) s = pb(s, n, gb(pt, n) ^ rkb(rk, 0, n));
    for (int r = 1; r <= 10; r++) begin
      t = '0;
      for (int n = 0; n < 16; n++)
        t = pb(t, n, sbox_t[gb(s, 4*(((n/4) + (n%4)) % 4) + (n%4))]);
      if (r < 10) begin
        m = '0;
        for (int c = 0; c < 4; c++) begin
          a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
          m = pb(m, 4*c,   gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3);
          m = pb(m, 4*c+1, a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3);
          m = pb(m, 4*c+2, a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03));
          m = pb(m, 4*c+3, gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02));
        end
        t = m;
      end
      s = '0;
      for (int n = 0; n < 16; n++) s = pb(s, n, gb(t, n) ^ rkb(rk, r, n));
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] pop_exp();
    if (sb_q.size() == 0) return 'x;
    return sb_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_accept(input logic [127:0] pt, input logic [1407:0] keys, output bit ok);
    int w = 0;
    while (bus.in_ready !== 1'b1 && w < 40) begin tick(); w++; end
    ok = (bus.in_ready === 1'b1);
    if (ok) begin
      bus.round_keys = keys;
      bus.data_in    = pt;
      bus.in_valid   = 1'b1;
      tick();
      bus.in_valid   = 1'b0;
      sb_q.push_back(model_enc(keys, pt));
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    if (bus.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic take_output();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.data_in = '0; bus.round_keys = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.data_out !== 128'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", bus.data_out); end
    checks++; if (dut.rc_q !== 4'd0) begin errors++; $display("FAIL reset_rc: got %0d expected 0", dut.rc_q); end
    checks++; if (dut.state_q !== 128'h0) begin errors++; $display("FAIL reset_state: got %h expected 0", dut.state_q); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_c1(input string name);
    bit ok; int lat; logic [127:0] exp;
    do_accept(C1_PT, key_expand(C1_KEY), ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_accept: in_ready never seen, expected 1", name); end
    wait_valid(lat);
    checks++; if (lat != 10) begin errors++; $display("FAIL %s_latency: got %0d expected 10", name, lat); end
    checks++; if (bus.data_out !== C1_CT) begin errors++; $display("FAIL %s_ct: got %h expected %h", name, bus.data_out, C1_CT); end
    exp = pop_exp();
    checks++; if (bus.data_out !== exp) begin errors++; $display("FAIL %s_model: got %h expected %h", name, bus.data_out, exp); end
    take_output();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_return_idle: in_ready=%b out_valid=%b expected 1/0", name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_fips_b();
    bit ok; int lat; logic [127:0] exp;
    do_accept(B_PT, key_expand(B_KEY), ok);
    tick();
    checks++; if (dut.state_q !== B_R1) begin errors++; $display("FAIL fipsb_round1: got %h expected %h", dut.state_q, B_R1); end
    wait_valid(lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL fipsb_latency: got %0d expected 9 after round 1", lat); end
    checks++; if (bus.data_out !== B_CT) begin errors++; $display("FAIL fipsb_ct: got %h expected %h", bus.data_out, B_CT); end
    exp = pop_exp();
    checks++; if (bus.data_out !== exp) begin errors++; $display("FAIL fipsb_model: got %h expected %h", bus.data_out, exp); end
    take_output();
  endtask

  task automatic test_sbox();
    logic [7:0] sin [4];
    logic [7:0] sout [4];
    bit ok; int lat; logic [127:0] exp;
    sin  = '{8'h00, 8'h01, 8'h53, 8'hff};
    sout = '{8'h63, 8'h7c, 8'hed, 8'h16};
    for (int i = 0; i < 4; i++) begin
      // zero keys and a uniform state make round 1 a pure S-box lookup in every byte
      do_accept({16{sin[2'(i)]}}, '0, ok);
      tick();
      checks++; if (dut.state_q !== {16{sout[2'(i)]}}) begin
        errors++; $display("FAIL sbox_%h: got %h expected %h", sin[2'(i)], dut.state_q, {16{sout[2'(i)]}});
      end
      wait_valid(lat);
      exp = pop_exp();
      checks++; if (bus.data_out !== exp) begin errors++; $display("FAIL sbox_run_%h: got %h expected %h", sin[2'(i)], bus.data_out, exp); end
      take_output();
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat; logic [127:0] held, exp;
    do_accept(rnd128(), key_expand(rnd128()), ok);
    wait_valid(lat);
    checks++; if (lat != 10) begin errors++; $display("FAIL bp_latency: got %0d expected 10", lat); end
    held = bus.data_out;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = (i % 2 == 1);
      bus.data_in  = rnd128();
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.data_out !== held) begin
        errors++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b data=%h expected 1/0/%h", i, bus.out_valid, bus.in_ready, bus.data_out, held);
      end
    end
    bus.in_valid = 1'b0;
    exp = pop_exp();
    checks++; if (bus.data_out !== exp) begin errors++; $display("FAIL bp_model: got %h expected %h", bus.data_out, exp); end
    take_output();
    tick();
    checks++; if (bus.in_ready !== 1'b1 || sb_q.size() != 0) begin
      errors++; $display("FAIL bp_ignored_inputs: in_ready=%b pending=%0d expected 1/0", bus.in_ready, sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0]  pts [4];
    logic [1407:0] kks [4];
    int acc_cyc [4];
    int k = 0;
    int n_out = 0;
    bit acc_now;
    logic [127:0] exp;
    for (int i = 0; i < 4; i++) begin
      pts[2'(i)] = rnd128(); kks[2'(i)] = key_expand(rnd128()); acc_cyc[2'(i)] = 0;
    end
    bus.round_keys = kks[0]; bus.data_in = pts[0];
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int cy = 0; cy < 100 && n_out < 4; cy++) begin
      acc_now = (bus.in_ready === 1'b1) && (k < 4);
      if (bus.out_valid === 1'b1) begin
        exp = pop_exp();
        checks++; if (bus.data_out !== exp) begin errors++; $display("FAIL b2b_data_%0d: got %h expected %h", n_out, bus.data_out, exp); end
        n_out++;
        // previous block has finished its last round, so the next key set may be presented now
        if (k < 4) bus.round_keys = kks[2'(k)];
      end
      if (acc_now) begin
        sb_q.push_back(model_enc(kks[2'(k)], pts[2'(k)]));
        acc_cyc[2'(k)] = cyc + 1;
      end
      tick();
      if (acc_now) begin
        k++;
        if (k < 4) bus.data_in = pts[2'(k)];
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checks++; if (n_out != 4) begin errors++; $display("FAIL b2b_count: got %0d outputs expected 4", n_out); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (acc_cyc[2'(i)] - acc_cyc[2'(i-1)] != 12) begin
        errors++; $display("FAIL b2b_spacing_%0d: got %0d clocks expected 12", i, acc_cyc[2'(i)] - acc_cyc[2'(i-1)]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int w = 0; int seen = 0;
    do_accept(C1_PT, key_expand(C1_KEY), ok);
    while (dut.rc_q !== 4'd5 && w < 20) begin tick(); w++; end
    checks++; if (dut.rc_q !== 4'd5) begin errors++; $display("FAIL rstmid_reach_rc5: got %0d expected 5", dut.rc_q); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.data_out !== 128'h0 || dut.rc_q !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_values: in_ready=%b out_valid=%b data=%h rc=%0d expected 1/0/0/0", bus.in_ready, bus.out_valid, bus.data_out, dut.rc_q);
    end
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_output: got %0d bad cycles expected 0", seen); end
    test_c1("c1_after_reset");
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_c1("c1");
    test_fips_b();
    test_sbox();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_encrypt_core.md
# aes_encrypt_core

Iterative AES-128 encryption datapath, one round per clock. Consumes the 1408-bit round-key bus from the key-expansion stage and a 128-bit plaintext block, and returns the ciphertext over a valid/ready handshake. It sits directly downstream of key expansion; key expansion is combinational, so this block is the first clocked stage of the cipher.

## Interface
- No parameters; AES-128 only (Nr = 10).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `round_keys` in 1408: expanded key. Word i is `round_keys[32i+31:32i]`, with row 0 in bits [31:24]. Round key r is words 4r..4r+3.
- `in_valid` in 1: plaintext offered.
- `in_ready` out 1: core idle and able to accept.
- `data_in` in 128: plaintext. State byte n (FIPS-197 index, column c = n/4, row n%4) is `data_in[8n+7:8n]`.
- `out_valid` out 1: ciphertext available.
- `out_ready` in 1: consumer takes the ciphertext.
- `data_out` out 128: ciphertext, same byte packing as `data_in`.

## Operation
- FSM states: IDLE, ROUND, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, load state ← `data_in` XOR round key 0, set round counter rc←1, go to ROUND.
  - ROUND: each edge, state ← SubBytes → ShiftRows → MixColumns (skipped when rc=10) → XOR round key rc. Then rc←rc+1. On the rc=10 edge, go to DONE.
  - DONE: `out_valid`=1 and `data_out` equals state. Hold until `out_ready`=1, then go to IDLE.
- Round-key byte for state byte n in round r is `round_keys[(4r+c)*32 + 31 - 8*row -: 8]`.
- SubBytes uses the true FIPS-197 S-box (GF(2^8) inverse followed by the affine transform, 0x63 constant). Implement it as a 256-entry case function with 16 instances, one per byte.
- MixColumns: xtime(b) = {b[6:0],1'b0} XOR (b[7] ? 8'h1b : 0). Coefficient matrix rows are 02 03 01 01, rotated per row.
- ShiftRows: row k rotates left by k columns.
- rc is a 4-bit counter. Values 0 and 11–15 are never used in ROUND; reaching one is an error and the bench checks for it.
- `round_keys` is not registered. The upstream stage holds it stable from the accept edge through the rc=10 edge. `data_in` is needed only in the accept cycle.
- `in_ready` and `out_valid` are decoded from the FSM state (registered state, no combinational path from the inputs).

## Timing
- Reset values: FSM=IDLE, rc=0, state=0, `data_out`=0, `out_valid`=0, `in_ready`=1.
- Accept occurs on the edge where `in_valid`=1 and `in_ready`=1 (edge E0).
- `out_valid` rises after E10, which is 10 clocks after accept.
- Output transfer occurs on the edge where `out_valid`=1 and `out_ready`=1. `in_ready` returns the following cycle. Minimum accept-to-accept spacing is 12 clocks.
- `in_valid` asserted outside IDLE is ignored; there is no queuing.
- `out_ready`=1 before `out_valid` has no effect. If `out_ready` is held high, DONE lasts exactly 1 cycle.
- `data_out` holds its value through DONE back-pressure and keeps the last result in IDLE until the next round 10 completes. `data_out` is undefined-free: it never shows partial rounds while `out_valid`=1.
- Reset asserted mid-operation: immediate return to reset values, no `out_valid` pulse, and the partial state is discarded.

## Test plan
- FIPS-197 C.1:
  - `round_keys` from key_in=128'h0f0e0d0c0b0a09080706050403020100.
  - `data_in`=128'hffeeddccbbaa99887766554433221100.
  - Required: `data_out`=128'h5ac5b47080b7cdd830047b6ad8e0c469 with `out_valid` exactly 10 clocks after accept.
- FIPS-197 Appendix B:
  - key 2b7e1516…09cf4f3c and plaintext 3243f6a8…e0370734, both byte-reversed onto the buses.
  - Required: ciphertext 3925841d02dc09fbdc118597196a0b32 (byte-reversed); intermediate state after round 1 matches the FIPS round-1 value.
- Back-pressure:
  - Hold `out_ready`=0 for 20 cycles after `out_valid`.
  - Required: `out_valid` and `data_out` stable, `in_ready`=0, and `in_valid` pulses during that window ignored.
- Back-to-back:
  - `in_valid` and `out_ready` tied high, 4 random blocks.
  - Required: accepts exactly 12 clocks apart and all results match the reference model.
- Reset at rc=5:
  - Required: `out_valid` never rises, `in_ready`=1 immediately, and a following C.1 run still produces the correct ciphertext.
- S-box spot checks via single-round probes:
  - Required: S(00)=63, S(01)=7c, S(53)=ed, S(ff)=16.
